// File: rtl/hazard_controller_pkg.sv
// Shared types and constants for the pipeline hazard controller: state and action
// encodings, the control-vector payload and the action decoder.
package hazard_controller_pkg;

  localparam int unsigned CNT_W_DEF       = 16;
  localparam int unsigned MEM_TIMEOUT_DEF = 255;
  localparam int unsigned REG_W           = 5;

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_LOAD_STALL = 2'd1,
    ST_MEM_WAIT   = 2'd2,
    ST_ILLEGAL    = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    ACT_NORMAL   = 2'd0,
    ACT_FREEZE   = 2'd1,
    ACT_BUBBLE   = 2'd2,
    ACT_REDIRECT = 2'd3
  } action_e;

  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic idex_write;
    logic exmem_write;
    logic if_flush;
    logic id_flush;
    logic pc_sel;
  } ctrl_t;

  // Expand an abstract action into the per-register control vector.
  function automatic ctrl_t action_ctrl(action_e act);
    ctrl_t c;
    c = '{pc_write: 1'b1, ifid_write: 1'b1, idex_write: 1'b1, exmem_write: 1'b1,
          if_flush: 1'b0, id_flush: 1'b0, pc_sel: 1'b0};
    case (act)
      ACT_FREEZE: begin
        c.pc_write    = 1'b0;
        c.ifid_write  = 1'b0;
        c.idex_write  = 1'b0;
        c.exmem_write = 1'b0;
      end
      ACT_BUBBLE: begin
        c.pc_write   = 1'b0;
        c.ifid_write = 1'b0;
        c.id_flush   = 1'b1;
      end
      ACT_REDIRECT: begin
        c.pc_sel   = 1'b1;
        c.if_flush = 1'b1;
      end
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/hazard_controller_if.sv
// Hazard inputs from the pipeline and control/statistics outputs back to it.
interface hazard_controller_if
  import hazard_controller_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
);

  logic             IDEX_MemoryRead;
  logic [REG_W-1:0] IDEX_rd;
  logic [REG_W-1:0] IFID_rs1;
  logic [REG_W-1:0] IFID_rs2;
  logic             IFID_use_rs1;
  logic             IFID_use_rs2;
  logic             branch_taken;
  logic             dmem_req;
  logic             dmem_ready;
  logic             cnt_clr;

  logic             PCWrite;
  logic             IFIDWrite;
  logic             IDEXWrite;
  logic             EXMEMWrite;
  logic             IF_flush;
  logic             ID_flush;
  logic             PCSel;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] flush_count;
  logic             mem_timeout_err;
  logic [1:0]       state_o;

  modport master (
    output IDEX_MemoryRead, IDEX_rd, IFID_rs1, IFID_rs2, IFID_use_rs1, IFID_use_rs2,
           branch_taken, dmem_req, dmem_ready, cnt_clr,
    input  PCWrite, IFIDWrite, IDEXWrite, EXMEMWrite, IF_flush, ID_flush, PCSel,
           stall_count, flush_count, mem_timeout_err, state_o
  );

  modport slave (
    input  IDEX_MemoryRead, IDEX_rd, IFID_rs1, IFID_rs2, IFID_use_rs1, IFID_use_rs2,
           branch_taken, dmem_req, dmem_ready, cnt_clr,
    output PCWrite, IFIDWrite, IDEXWrite, EXMEMWrite, IF_flush, ID_flush, PCSel,
           stall_count, flush_count, mem_timeout_err, state_o
  );

endinterface

// File: rtl/hazard_controller_sat_counter.sv
// Saturating event counter with synchronous clear; clear beats increment.
module sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      q <= '0;
    end else if (inc && (q != '1)) begin
      q <= q + WIDTH'(1);
    end
  end

endmodule

// File: rtl/hazard_controller.sv
// Pipeline hazard scheduler: arbitrates memory wait, load-use and taken-branch
// into one control vector per cycle and keeps stall/flush statistics.
module hazard_controller
  import hazard_controller_pkg::*;
#(
  parameter int unsigned CNT_W       = CNT_W_DEF,
  parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  hazard_controller_if.slave bus
);

  localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              timeout_err_q;
  logic              timeout_c;
  logic              lu_c;
  logic              mem_stall_c;
  logic              wait_expired_c;
  action_e           act_c;
  ctrl_t             ctrl_c;
  logic [CNT_W-1:0]  stall_count_q;
  logic [CNT_W-1:0]  flush_count_q;

  assign lu_c = bus.IDEX_MemoryRead && (bus.IDEX_rd != '0) &&
                ((bus.IFID_use_rs1 && (bus.IDEX_rd == bus.IFID_rs1)) ||
                 (bus.IFID_use_rs2 && (bus.IDEX_rd == bus.IFID_rs2)));
  assign mem_stall_c    = bus.dmem_req && !bus.dmem_ready;
  assign wait_expired_c = (wait_cnt_q == WAIT_W'(MEM_TIMEOUT));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_RUN;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  always_comb begin
    state_d    = ST_RUN;
    wait_cnt_d = wait_cnt_q;
    timeout_c  = 1'b0;
    case (state_q)
      ST_RUN, ST_LOAD_STALL: begin
        if (mem_stall_c) begin
          state_d    = ST_MEM_WAIT;
          wait_cnt_d = WAIT_W'(1);
        end else if ((state_q == ST_RUN) && lu_c) begin
          state_d = ST_LOAD_STALL;
        end
      end
      ST_MEM_WAIT: begin
        if (bus.dmem_ready) begin
          wait_cnt_d = '0;
        end else if (wait_expired_c) begin
          wait_cnt_d = '0;
          timeout_c  = 1'b1;
        end else begin
          state_d    = ST_MEM_WAIT;
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end
      default: ;
    endcase
  end

  // Load-use is only honoured from RUN so a stall costs exactly one bubble.
  always_comb begin
    act_c = ACT_NORMAL;
    case (state_q)
      ST_RUN: begin
        if (mem_stall_c)           act_c = ACT_FREEZE;
        else if (lu_c)             act_c = ACT_BUBBLE;
        else if (bus.branch_taken) act_c = ACT_REDIRECT;
      end
      ST_LOAD_STALL: begin
        if (mem_stall_c)           act_c = ACT_FREEZE;
        else if (bus.branch_taken) act_c = ACT_REDIRECT;
      end
      ST_MEM_WAIT: begin
        if (!bus.dmem_ready && !wait_expired_c) act_c = ACT_FREEZE;
      end
      default: ;
    endcase
    ctrl_c = reset ? ctrl_t'('0) : action_ctrl(act_c);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      timeout_err_q <= 1'b0;
    end else if (timeout_c) begin
      timeout_err_q <= 1'b1;
    end else if (bus.cnt_clr) begin
      timeout_err_q <= 1'b0;
    end
  end

  sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (bus.cnt_clr),
    .inc   (!ctrl_c.pc_write),
    .q     (stall_count_q)
  );

  sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (bus.cnt_clr),
    .inc   (ctrl_c.if_flush),
    .q     (flush_count_q)
  );

  assign bus.PCWrite         = ctrl_c.pc_write;
  assign bus.IFIDWrite       = ctrl_c.ifid_write;
  assign bus.IDEXWrite       = ctrl_c.idex_write;
  assign bus.EXMEMWrite      = ctrl_c.exmem_write;
  assign bus.IF_flush        = ctrl_c.if_flush;
  assign bus.ID_flush        = ctrl_c.id_flush;
  assign bus.PCSel           = ctrl_c.pc_sel;
  assign bus.stall_count     = stall_count_q;
  assign bus.flush_count     = flush_count_q;
  assign bus.mem_timeout_err = timeout_err_q;
  assign bus.state_o         = 2'(state_q);

endmodule

// File: tb/tb_hazard_controller.sv
// Directed scoreboard bench for hazard_controller (CNT_W=4, MEM_TIMEOUT=4).
module tb_hazard_controller;

  localparam int unsigned CW = 4;
  // {PCWrite, IFIDWrite, IDEXWrite, EXMEMWrite, IF_flush, ID_flush, PCSel}
  localparam logic [6:0] C_NORM = 7'b1111000;
  localparam logic [6:0] C_FRZ  = 7'b0000000;
  localparam logic [6:0] C_BUB  = 7'b0011010;
  localparam logic [6:0] C_RDR  = 7'b1111101;
  localparam logic [6:0] C_RST  = 7'b0000000;

  typedef struct {
    logic [6:0]    ctrl;
    logic [1:0]    st;
    logic [CW-1:0] sc;
    logic [CW-1:0] fc;
    logic          err;
    string         tag;
  } exp_t;

  logic clk;
  logic reset;
  exp_t sb_q[$];
  int unsigned vectors;
  int unsigned miscompares;
  logic [CW-1:0] sc_m;
  logic [CW-1:0] fc_m;

  hazard_controller_if #(.CNT_W(CW)) bus ();

  hazard_controller #(.CNT_W(CW), .MEM_TIMEOUT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [CW-1:0] sat_inc(logic [CW-1:0] v, logic en);
    return (en && (v != {CW{1'b1}})) ? v + CW'(1) : v;
  endfunction

  task automatic in(logic mr, logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2,
                    logic u1, logic u2, logic br, logic req, logic rdy, logic clr);
    bus.IDEX_MemoryRead = mr;
    bus.IDEX_rd         = rd;
    bus.IFID_rs1        = rs1;
    bus.IFID_rs2        = rs2;
    bus.IFID_use_rs1    = u1;
    bus.IFID_use_rs2    = u2;
    bus.branch_taken    = br;
    bus.dmem_req        = req;
    bus.dmem_ready      = rdy;
    bus.cnt_clr         = clr;
  endtask

  task automatic check(string tag, string what, logic [7:0] obs, logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s/%s observed=%0h expected=%0h", tag, what, obs, exp);
    end
  endtask

  // One cycle: push expectation, advance count model, compare mid-cycle.
  task automatic cyc(logic [6:0] ctrl, logic [1:0] st, logic err, string tag);
    exp_t e;
    e.ctrl = ctrl; e.st = st; e.sc = sc_m; e.fc = fc_m; e.err = err; e.tag = tag;
    sb_q.push_back(e);
    if (reset || bus.cnt_clr) begin
      sc_m = '0;
      fc_m = '0;
    end else begin
      sc_m = sat_inc(sc_m, !ctrl[6]);
      fc_m = sat_inc(fc_m, ctrl[2]);
    end
    @(negedge clk);
    if (sb_q.size() == 0) begin
      vectors++;
      miscompares++;
      $error("FAIL %s scoreboard empty observed=0 expected=1", tag);
    end else begin
      e = sb_q.pop_front();
      check(e.tag, "ctrl", 8'({bus.PCWrite, bus.IFIDWrite, bus.IDEXWrite, bus.EXMEMWrite,
                               bus.IF_flush, bus.ID_flush, bus.PCSel}), 8'(e.ctrl));
      check(e.tag, "state", 8'(bus.state_o), 8'(e.st));
      check(e.tag, "stall_count", 8'(bus.stall_count), 8'(e.sc));
      check(e.tag, "flush_count", 8'(bus.flush_count), 8'(e.fc));
      check(e.tag, "timeout_err", 8'(bus.mem_timeout_err), 8'(e.err));
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    clk = 1'b0;
    reset = 1'b1;
    vectors = 0;
    miscompares = 0;
    sc_m = '0;
    fc_m = '0;
    in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    cyc(C_RST, 2'd0, 1'b0, "reset");
    reset = 1'b0;
    cyc(C_NORM, 2'd0, 1'b0, "idle");

    // load-use on rs1, single bubble
    in(1, 5, 5, 0, 1, 0, 0, 0, 0, 0);
    cyc(C_BUB, 2'd0, 1'b0, "lu_rs1");
    cyc(C_NORM, 2'd1, 1'b0, "lu_held");
    // x0 destination and unused rs2 never stall
    in(1, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    cyc(C_NORM, 2'd0, 1'b0, "x0");
    in(1, 7, 0, 7, 0, 0, 0, 0, 0, 0);
    cyc(C_NORM, 2'd0, 1'b0, "rs2_unused");
    in(1, 7, 0, 7, 0, 1, 0, 0, 0, 0);
    cyc(C_BUB, 2'd0, 1'b0, "lu_rs2");
    in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(C_NORM, 2'd1, 1'b0, "after_lu_rs2");

    // branches
    in(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    cyc(C_RDR, 2'd0, 1'b0, "branch");
    in(1, 3, 3, 0, 1, 0, 1, 0, 0, 0);
    cyc(C_BUB, 2'd0, 1'b0, "br_lu");
    cyc(C_RDR, 2'd1, 1'b0, "br_in_ls");
    in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(C_NORM, 2'd0, 1'b0, "post_br");

    // memory wait released by ready after three frozen cycles
    in(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    cyc(C_FRZ, 2'd0, 1'b0, "mw_enter");
    in(1, 3, 3, 0, 1, 0, 1, 1, 0, 0);
    cyc(C_FRZ, 2'd2, 1'b0, "mw_ignore");
    in(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    cyc(C_FRZ, 2'd2, 1'b0, "mw_3");
    in(0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    cyc(C_NORM, 2'd2, 1'b0, "mw_ready");
    in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(C_NORM, 2'd0, 1'b0, "mw_done");

    // memory stall takes priority in LOAD_STALL
    in(1, 5, 5, 0, 1, 0, 0, 0, 0, 0);
    cyc(C_BUB, 2'd0, 1'b0, "ls_lu");
    in(1, 5, 5, 0, 1, 0, 0, 1, 0, 0);
    cyc(C_FRZ, 2'd1, 1'b0, "ls_mem");
    in(0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    cyc(C_NORM, 2'd2, 1'b0, "ls_mem_rdy");
    in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(C_NORM, 2'd0, 1'b0, "ls_done");

    // timeout: four frozen cycles, forced release, flag next cycle
    in(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    cyc(C_FRZ, 2'd0, 1'b0, "to_0");
    for (int i = 0; i < 3; i++) cyc(C_FRZ, 2'd2, 1'b0, "to_frz");
    cyc(C_NORM, 2'd2, 1'b0, "to_release");
    in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(C_NORM, 2'd0, 1'b1, "to_err");
    in(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    cyc(C_NORM, 2'd0, 1'b1, "clr");
    in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(C_NORM, 2'd0, 1'b0, "after_clr");

    // same-cycle timeout beats clear
    in(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    cyc(C_FRZ, 2'd0, 1'b0, "to2_0");
    for (int i = 0; i < 3; i++) cyc(C_FRZ, 2'd2, 1'b0, "to2_frz");
    in(0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
    cyc(C_NORM, 2'd2, 1'b0, "to2_clr_release");
    in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(C_NORM, 2'd0, 1'b1, "to2_wins");

    // reset in the middle of MEM_WAIT
    in(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    cyc(C_FRZ, 2'd0, 1'b1, "rst_mw0");
    cyc(C_FRZ, 2'd2, 1'b1, "rst_mw1");
    reset = 1'b1;
    cyc(C_RST, 2'd2, 1'b1, "rst_mid");
    reset = 1'b0;
    in(0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    cyc(C_NORM, 2'd0, 1'b0, "rst_after");

    // stall counter saturation at 15
    in(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    cyc(C_NORM, 2'd0, 1'b0, "sat_clr");
    for (int i = 0; i < 20; i++) begin
      in(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      cyc(C_FRZ, 2'd0, 1'b0, "sat_frz");
      in(0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
      cyc(C_NORM, 2'd2, 1'b0, "sat_rel");
    end
    in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(C_NORM, 2'd0, 1'b0, "sat_hold");
    check("sat_model", "stall_count", 8'(bus.stall_count), 8'd15);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
